// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Shares the write port of a single fifo between two valid/ready producers.
//   Arbitration is round-robin with burst locking. The current owner keeps the
//   port for up to BURST_LEN consecutive words while the other requester waits.
//   The block also sequences a fifo flush. It pulses fifo_sclr for one cycle,
//   then holds off writes until the fifo reports empty.
//
// Parameters:
//   DW         data width, equal to the fifo din width
//   BURST_LEN  maximum consecutive words per owner under contention (1..15)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   req0_valid   requester 0 has a word
//   req0_data    requester 0 word
//   req0_ready   requester 0 word accepted when valid & ready
//   req1_valid   requester 1 has a word
//   req1_data    requester 1 word
//   req1_ready   requester 1 word accepted when valid & ready
//   flush_req    single-cycle request to clear the fifo
//   flush_busy   high while a flush is in progress
//   fifo_full    full flag from the fifo
//   fifo_empty   empty flag from the fifo
//   fifo_wren    fifo write enable (same cycle as the accept)
//   fifo_din     fifo write data (req0_data when nothing is granted)
//   fifo_sclr    fifo synchronous clear, driven from a flop
//   wr_cnt0/1    (FIFO_ARB_STATS_EN only) wrapping 16-bit accepted-word counts
//
// Configuration macro:
//   FIFO_ARB_STATS_EN  adds per-requester accepted-word counters
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          flush_req,
    output logic          flush_busy,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic          fifo_wren,
    output logic [DW-1:0] fifo_din,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]   wr_cnt0,
    output logic [15:0]   wr_cnt1,
`endif
    output logic          fifo_sclr
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_CLR  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner;
    logic [3:0] r_burst_cnt;
    logic       r_sclr;

    logic [1:0] w_valid;
    logic       w_grant;
    logic       w_grant_vld;
    logic       w_go;

    assign w_valid = {req1_valid, req0_valid};

    // Grant is decoded from registered owner/credit, so it settles before the
    // edge. The owner keeps the port while it has credit. Otherwise the other
    // side wins if valid. Failing that, the owner continues without credit.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_vld = 1'b0;
        if (w_valid[r_owner] && (r_burst_cnt < BURST_MAX)) begin
            w_grant     = r_owner;
            w_grant_vld = 1'b1;
        end else if (w_valid[~r_owner]) begin
            w_grant     = ~r_owner;
            w_grant_vld = 1'b1;
        end else if (w_valid[r_owner]) begin
            w_grant     = r_owner;
            w_grant_vld = 1'b1;
        end
    end

    // Gating with reset keeps readies and wren low while reset is held, even
    // though the state register already reads RUN.
    assign w_go = !reset && (r_state == ST_RUN) && !flush_req && !fifo_full
                  && w_grant_vld;

    assign req0_ready = w_go && (w_grant == 1'b0);
    assign req1_ready = w_go && (w_grant == 1'b1);
    assign fifo_wren  = w_go;
    assign fifo_din   = (w_grant_vld && w_grant) ? req1_data : req0_data;
    assign flush_busy = (r_state != ST_RUN);
    assign fifo_sclr  = r_sclr;

    // Flush sequencing: next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:  if (flush_req) w_state_nxt = ST_CLR;
            ST_CLR:  w_state_nxt = ST_WAIT;
            ST_WAIT: if (fifo_empty) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_sclr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Registered clear is high exactly during the CLR cycle.
            r_sclr  <= (w_state_nxt == ST_CLR);
        end
    end

    // Owner and burst credit. Reset and the CLR state both leave the owner
    // with no credit, so the next contested grant goes to requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= 1'b1;
            r_burst_cnt <= BURST_MAX;
        end else if (r_state == ST_CLR) begin
            r_owner     <= 1'b1;
            r_burst_cnt <= BURST_MAX;
        end else if (w_go) begin
            if (w_grant != r_owner) begin
                r_owner     <= w_grant;
                r_burst_cnt <= 4'd1;
            end else if (r_burst_cnt < BURST_MAX) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_wr_cnt0;
    logic [15:0] r_wr_cnt1;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_cnt0 <= 16'd0;
            r_wr_cnt1 <= 16'd0;
        end else if (r_state == ST_CLR) begin
            r_wr_cnt0 <= 16'd0;
            r_wr_cnt1 <= 16'd0;
        end else begin
            if (req0_ready) r_wr_cnt0 <= r_wr_cnt0 + 16'd1;
            if (req1_ready) r_wr_cnt1 <= r_wr_cnt1 + 16'd1;
        end
    end

    assign wr_cnt0 = r_wr_cnt0;
    assign wr_cnt1 = r_wr_cnt1;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed testbench for fifo_wr_arbiter with DW=8 and BURST_LEN=4.
// Inputs change 1 ns after a rising edge. Outputs are compared a further
// 1 ns later, well before the next edge. Counter checks are guarded by
// FIFO_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          flush_req, flush_busy;
    logic          fifo_full, fifo_empty;
    logic          fifo_wren, fifo_sclr;
    logic [DW-1:0] fifo_din;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]   wr_cnt0, wr_cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DW(DW), .BURST_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_wren  (fifo_wren),
        .fifo_din   (fifo_din),
`ifdef FIFO_ARB_STATS_EN
        .wr_cnt0    (wr_cnt0),
        .wr_cnt1    (wr_cnt1),
`endif
        .fifo_sclr  (fifo_sclr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // g: 0/1 = that requester is granted and written, -1 = no write.
    task automatic check_grant(input string tag, input int g);
        check({tag, ".rdy0"}, 32'(req0_ready), 32'(g == 0));
        check({tag, ".rdy1"}, 32'(req1_ready), 32'(g == 1));
        check({tag, ".wren"}, 32'(fifo_wren),  32'(g >= 0));
        if (g == 0) check({tag, ".din"}, 32'(fifo_din), 32'(req0_data));
        if (g == 1) check({tag, ".din"}, 32'(fifo_din), 32'(req1_data));
    endtask

    int exp1[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h5A;
        req1_data  = 8'hA5;
        flush_req  = 1'b0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;

        // Reset held with both requesters valid: all outputs stay quiet.
        tick();
        tick();
        check_grant("rst", -1);
        check("rst.busy", 32'(flush_busy), 32'd0);
        check("rst.sclr", 32'(fifo_sclr), 32'd0);
`ifdef FIFO_ARB_STATS_EN
        check("rst.cnt0", 32'(wr_cnt0), 32'd0);
        check("rst.cnt1", 32'(wr_cnt1), 32'd0);
`endif
        reset = 1'b0;

        // Test 1: both valid, round-robin in bursts of 4.
        for (int i = 0; i < 12; i++) begin
            req0_data = 8'(8'h10 + i);
            req1_data = 8'(8'h80 + i);
            #1;
            check_grant($sformatf("t1.%0d", i), exp1[i]);
            tick();
        end

        // Test 2: req0 alone, 6 back-to-back writes.
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0_data = 8'(8'h11 + i);
            #1;
            check_grant($sformatf("t2.%0d", i), 0);
            check($sformatf("t2.din%0d", i), 32'(fifo_din), 32'(8'h11 + i));
            tick();
        end

        // Test 3: fifo full stalls everything; sequence resumes with req1.
        req1_valid = 1'b1;
        fifo_full  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_grant($sformatf("t3.full%0d", i), -1);
            tick();
        end
        fifo_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_grant($sformatf("t3.res%0d", i), (i < 4) ? 1 : 0);
            tick();
        end

        // Test 4: req0 has burst_cnt=2 after one more write. Then it drops
        // valid, req1 takes over with burst_cnt=1 and gets only 3 more words.
        #1;
        check_grant("t4.pre", 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check_grant("t4.sw", 1);
        tick();
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_grant($sformatf("t4.b%0d", i), (i < 3) ? 1 : 0);
            tick();
        end

        // Test 5: flush with both valid. Flush wins and no write occurs.
        flush_req  = 1'b1;
        fifo_empty = 1'b0;
        #1;
        check_grant("t5.req", -1);
        check("t5.req.busy", 32'(flush_busy), 32'd0);
        tick();
        flush_req = 1'b0;
        #1;
        check_grant("t5.clr", -1);
        check("t5.clr.sclr", 32'(fifo_sclr), 32'd1);
        check("t5.clr.busy", 32'(flush_busy), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            flush_req = (i == 1);  // ignored in WAIT
            #1;
            check_grant($sformatf("t5.w%0d", i), -1);
            check($sformatf("t5.w%0d.sclr", i), 32'(fifo_sclr), 32'd0);
            check($sformatf("t5.w%0d.busy", i), 32'(flush_busy), 32'd1);
            tick();
        end
        flush_req  = 1'b0;
        fifo_empty = 1'b1;
        #1;
        check("t5.e.busy", 32'(flush_busy), 32'd1);
        check_grant("t5.e", -1);
        tick();
        #1;
        check("t5.run.busy", 32'(flush_busy), 32'd0);
        check_grant("t5.run", 0);
        tick();

        // Reset in the middle of a flush drops fifo_sclr at once.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        #1;
        check("rmf.sclr_pre", 32'(fifo_sclr), 32'd1);
        reset = 1'b1;
        #1;
        check("rmf.sclr", 32'(fifo_sclr), 32'd0);
        check("rmf.busy", 32'(flush_busy), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_grant("rmf.run", 0);

`ifdef FIFO_ARB_STATS_EN
        // Test 6: accepted-word counters.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        req1_valid = 1'b0;
        #1;
        check("t6.cnt0", 32'(wr_cnt0), 32'd5);
        check("t6.cnt1", 32'(wr_cnt1), 32'd3);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        check("t6.clr0", 32'(wr_cnt0), 32'd0);
        check("t6.clr1", 32'(wr_cnt1), 32'd0);
        tick();  // WAIT -> RUN (fifo_empty is 1)
        req0_valid = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        req0_valid = 1'b0;
        #1;
        check("t6.ffff", 32'(wr_cnt0), 32'hFFFF);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        #1;
        check("t6.wrap", 32'(wr_cnt0), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
